// File: rtl/llfifo_pop_scheduler.sv
// Push/pop controller for the shared linked-list multi-queue FIFO.
// The push path is a combinational pass-through with full backpressure.
// The pop path does round-robin over eligible queues, with bursts of up to
// BURST pops, into a registered valid/ready egress stage.
module llfifo_pop_scheduler #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_FIFOS   = 2,
  parameter int unsigned SEL_WIDTH   = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1,
  parameter int unsigned BURST       = 2,
  parameter int unsigned BURST_WIDTH = $clog2(BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [SEL_WIDTH-1:0] in_sel,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 push,
  output logic [SEL_WIDTH-1:0] push_sel,
  output logic [WIDTH-1:0]     data_in,
  input  logic                 full,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     data_out,
  output logic                 pop,
  output logic [SEL_WIDTH-1:0] pop_sel,
  input  logic [NUM_FIFOS-1:0] q_enable,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel,
  input  logic                 out_ready
);

  localparam logic [BURST_WIDTH-1:0] BURST_MAX = BURST_WIDTH'(BURST);
  localparam logic [SEL_WIDTH-1:0]   LAST_Q    = SEL_WIDTH'(NUM_FIFOS - 1);

  logic [SEL_WIDTH-1:0]   cur_q, cur_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d;
  logic [WIDTH-1:0]       out_data_q, out_data_d;
  logic [SEL_WIDTH-1:0]   out_sel_q, out_sel_d;

  logic [NUM_FIFOS-1:0]   elig;
  logic [SEL_WIDTH-1:0]   grant;
  logic [SEL_WIDTH-1:0]   scan_sel;
  logic                   keep_cur;
  logic                   can_load;

  // Push side: forward writes and never push into a full buffer or during reset.
  assign in_ready = rst & ~full;
  assign push     = in_valid & in_ready;
  assign push_sel = in_sel;
  assign data_in  = in_data;

  assign elig     = ~empty & q_enable;
  assign can_load = ~out_valid_q | out_ready;

  // Grant selection. cnt_q == 0 means no burst is open (only after reset), so cur is not favoured.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    scan_sel = '0;
    keep_cur = (cnt_q != '0) && (cnt_q < BURST_MAX) && elig[cur_q];
    for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
      idx = (32'(cur_q) + k) % NUM_FIFOS;
      if (!found && elig[SEL_WIDTH'(idx)]) begin
        found    = 1'b1;
        scan_sel = SEL_WIDTH'(idx);
      end
    end
    grant = keep_cur ? cur_q : scan_sel;
  end

  assign pop     = rst & can_load & (|elig);
  assign pop_sel = grant;

  // Next-state for the scheduler and the egress register.
  always_comb begin
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (pop) begin
      out_valid_d = 1'b1;
      out_data_d  = data_out;
      out_sel_d   = grant;
      if ((grant == cur_q) && (cnt_q < BURST_MAX)) begin
        cnt_d = cnt_q + BURST_WIDTH'(1);
      end else begin
        cur_d = grant;
        cnt_d = BURST_WIDTH'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_q       <= LAST_Q;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_llfifo_pop_scheduler.sv
// Directed testbench for llfifo_pop_scheduler (NUM_FIFOS=2, BURST=2, WIDTH=8).
module tb_llfifo_pop_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [0:0] in_sel = '0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       push;
  logic [0:0] push_sel;
  logic [7:0] data_in;
  logic       full = 1'b0;
  logic [1:0] empty = 2'b11;
  logic [7:0] data_out = '0;
  logic       pop;
  logic [0:0] pop_sel;
  logic [1:0] q_enable = 2'b11;
  logic       out_valid;
  logic [7:0] out_data;
  logic [0:0] out_sel;
  logic       out_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  llfifo_pop_scheduler #(.WIDTH(8), .NUM_FIFOS(2), .BURST(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .push(push), .push_sel(push_sel), .data_in(data_in),
    .full(full), .empty(empty), .data_out(data_out),
    .pop(pop), .pop_sel(pop_sel), .q_enable(q_enable),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [0:0]  isel;
    logic [7:0]  idata;
    logic        full;
    logic [1:0]  empty;
    logic [7:0]  dout;
    logic [1:0]  qen;
    logic        ordy;
    logic [22:0] exp;
  } vec_t;

  // Expected-output packing: {in_ready, push, push_sel, data_in, pop, pop_sel, out_valid, out_sel, out_data}
  function automatic logic [22:0] e(input logic ir, input logic ps, input logic pss,
                                    input logic [7:0] din, input logic pp, input logic pps,
                                    input logic ov, input logic os, input logic [7:0] od);
    return {ir, ps, pss, din, pp, pps, ov, os, od};
  endfunction

  function automatic vec_t mk(input logic r, input logic iv, input logic isel, input logic [7:0] idata,
                              input logic f, input logic [1:0] em, input logic [7:0] dout,
                              input logic [1:0] qen, input logic ordy, input logic [22:0] ex);
    vec_t v;
    v.rst = r; v.iv = iv; v.isel = isel; v.idata = idata; v.full = f;
    v.empty = em; v.dout = dout; v.qen = qen; v.ordy = ordy; v.exp = ex;
    return v;
  endfunction

  function automatic logic [22:0] actual();
    return {in_ready, push, push_sel, data_in, pop, pop_sel, out_valid, out_sel, out_data};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam int NV = 20;
  vec_t vecs[NV];

  initial begin
    // rst held 0 from time 0; the posedge at t=5 resets the DUT before row 0.
    vecs[0]  = mk(0,1,1,8'hAA,0,2'b00,8'h11,2'b11,1, e(0,0,1,8'hAA,0,0,0,0,8'h00));
    vecs[1]  = mk(0,1,1,8'hAA,0,2'b00,8'h11,2'b11,1, e(0,0,1,8'hAA,0,0,0,0,8'h00));
    vecs[2]  = mk(1,0,0,8'hAA,0,2'b00,8'hA0,2'b11,1, e(1,0,0,8'hAA,1,0,0,0,8'h00));
    vecs[3]  = mk(1,0,0,8'hAA,0,2'b00,8'hA1,2'b11,1, e(1,0,0,8'hAA,1,0,1,0,8'hA0));
    vecs[4]  = mk(1,0,0,8'hAA,0,2'b00,8'hB0,2'b11,1, e(1,0,0,8'hAA,1,1,1,0,8'hA1));
    vecs[5]  = mk(1,0,0,8'hAA,0,2'b00,8'hB1,2'b11,1, e(1,0,0,8'hAA,1,1,1,1,8'hB0));
    vecs[6]  = mk(1,0,0,8'hAA,0,2'b00,8'hA2,2'b11,1, e(1,0,0,8'hAA,1,0,1,1,8'hB1));
    vecs[7]  = mk(1,0,0,8'hAA,0,2'b00,8'hA3,2'b11,1, e(1,0,0,8'hAA,1,0,1,0,8'hA2));
    vecs[8]  = mk(1,0,0,8'hAA,0,2'b00,8'hC0,2'b11,0, e(1,0,0,8'hAA,0,1,1,0,8'hA3));
    vecs[9]  = mk(1,0,0,8'hAA,0,2'b00,8'hC1,2'b11,0, e(1,0,0,8'hAA,0,1,1,0,8'hA3));
    vecs[10] = mk(1,0,0,8'hAA,0,2'b00,8'hC2,2'b11,0, e(1,0,0,8'hAA,0,1,1,0,8'hA3));
    vecs[11] = mk(1,0,0,8'hAA,0,2'b00,8'hB2,2'b11,1, e(1,0,0,8'hAA,1,1,1,0,8'hA3));
    vecs[12] = mk(1,0,0,8'hAA,0,2'b00,8'hB3,2'b10,1, e(1,0,0,8'hAA,1,1,1,1,8'hB2));
    vecs[13] = mk(1,0,0,8'hAA,0,2'b00,8'hB4,2'b10,1, e(1,0,0,8'hAA,1,1,1,1,8'hB3));
    vecs[14] = mk(1,0,0,8'hAA,0,2'b00,8'hB5,2'b11,1, e(1,0,0,8'hAA,1,1,1,1,8'hB4));
    vecs[15] = mk(1,0,0,8'hAA,0,2'b00,8'hA4,2'b11,1, e(1,0,0,8'hAA,1,0,1,1,8'hB5));
    vecs[16] = mk(1,0,0,8'hAA,0,2'b11,8'h00,2'b11,1, e(1,0,0,8'hAA,0,0,1,0,8'hA4));
    vecs[17] = mk(1,1,1,8'hCC,1,2'b00,8'h00,2'b00,1, e(0,0,1,8'hCC,0,0,0,0,8'hA4));
    vecs[18] = mk(1,1,1,8'hCC,0,2'b00,8'h00,2'b00,1, e(1,1,1,8'hCC,0,0,0,0,8'hA4));
    vecs[19] = mk(1,1,1,8'hCC,1,2'b00,8'h00,2'b00,1, e(0,0,1,8'hCC,0,0,0,0,8'hA4));

    // Cycle-by-cycle table: drive at negedge, sample 1 time unit later.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].iv; in_sel = vecs[i].isel; in_data = vecs[i].idata;
      full = vecs[i].full; empty = vecs[i].empty; data_out = vecs[i].dout;
      q_enable = vecs[i].qen; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
    end

    // Sole eligible queue 1 with five words: back-to-back pops, no bubbles.
    in_valid = 1'b0; full = 1'b0; q_enable = 2'b11; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      empty = 2'b01; data_out = 8'h50 + 8'(i);
      #1;
      check($sformatf("sole_pop%0d", i), {30'd0, pop, pop_sel}, 32'h3);
      if (i > 0)
        check($sformatf("sole_out%0d", i), {22'd0, out_valid, out_sel, out_data},
              {22'd0, 1'b1, 1'b1, 8'h50 + 8'(i - 1)});
    end
    @(negedge clk);
    empty = 2'b11;
    #1;
    check("sole_tail", {21'd0, pop, out_valid, out_sel, out_data}, {21'd0, 1'b0, 1'b1, 1'b1, 8'h54});
    @(negedge clk);
    #1;
    check("sole_drain", {31'd0, out_valid}, 32'd0);

    // Reset while a word is held under backpressure discards it; first grant afterwards is queue 0.
    empty = 2'b00; out_ready = 1'b0; data_out = 8'h77;
    #1;
    check("pend_pop", {30'd0, pop, pop_sel}, 32'h3);
    @(negedge clk);
    data_out = 8'h78;
    #1;
    check("pend_hold", {20'd0, pop, out_valid, out_sel, out_data, 1'b0}, {20'd0, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_comb", {29'd0, pop, in_ready, push}, 32'd0);
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    check("rst_regs", {22'd0, out_valid, out_sel, out_data}, 32'd0);
    check("rst_grant", {30'd0, pop, pop_sel}, 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/llfifo_pop_scheduler.md
Name: llfifo_pop_scheduler

Overview:
- Controller that owns both sides of the shared linked-list multi-queue FIFO (linked_list_fifo).
- Push side: admits upstream writes with full backpressure.
- Pop side: picks a non-empty, enabled queue by round-robin, with up to BURST consecutive pops per queue, and moves each popped word into a registered valid/ready output stage.
- Sits between the ingress demux and the single egress consumer of the shared buffer.

Parameters:
- WIDTH, 8, data width; must match linked_list_fifo WIDTH.
- NUM_FIFOS, 2, number of logical queues.
- SEL_WIDTH, $clog2(NUM_FIFOS) (minimum 1), queue-select width.
- BURST, 2, maximum consecutive pops granted to one queue before rotating; must be at least 1.
- BURST_WIDTH, $clog2(BURST+1), width of the burst counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (0 = in reset).
- in_valid  in  1  upstream write request.
- in_sel  in  SEL_WIDTH  target queue of the write.
- in_data  in  WIDTH  write data.
- in_ready  out  1  write accepted when in_valid & in_ready.
- push  out  1  to fifo push.
- push_sel  out  SEL_WIDTH  to fifo push_sel.
- data_in  out  WIDTH  to fifo data_in.
- full  in  1  from fifo; shared storage is full.
- empty  in  NUM_FIFOS  from fifo; per-queue empty flags.
- data_out  in  WIDTH  from fifo; head word of the queue selected by pop_sel, valid in the same cycle.
- pop  out  1  to fifo pop.
- pop_sel  out  SEL_WIDTH  to fifo pop_sel.
- q_enable  in  NUM_FIFOS  per-queue service enable; 0 masks the queue from scheduling.
- out_valid  out  1  egress word valid.
- out_data  out  WIDTH  egress word.
- out_sel  out  SEL_WIDTH  queue the egress word came from.
- out_ready  in  1  egress consumer ready.

Behaviour:
- Push path is combinational, no storage:
  - in_ready = rst & ~full.
  - push = in_valid & in_ready.
  - push_sel = in_sel; data_in = in_data.
  - Never pushes while full, so the fifo's "no push when full" assumption always holds.
- Eligibility: elig[i] = ~empty[i] & q_enable[i], taken from flags in the current cycle.
  - A push this cycle does not make an empty queue eligible until the cycle after.
- Scheduler state: cur (SEL_WIDTH) is the last-served queue; cnt (BURST_WIDTH) is consecutive pops from cur.
- Grant, combinational:
  - If elig[cur] and cnt < BURST: grant = cur.
  - Otherwise grant = the first eligible index scanning cur+1, cur+2, … modulo NUM_FIFOS.
  - cur itself is examined last, so it is re-granted only if it is the sole eligible queue.
- Output stage: can_load = ~out_valid | out_ready.
  - pop = rst & can_load & |elig.
  - pop_sel = grant (0 when no queue is eligible).
- On a cycle with pop:
  - out_data <= data_out; out_sel <= grant; out_valid <= 1.
  - If grant == cur and cnt < BURST: cnt <= cnt+1.
  - Otherwise: cur <= grant and cnt <= 1. This covers burst exhaustion, the sole-eligible re-grant and queue switches.
- On a cycle without pop: if out_ready, out_valid <= 0. cur and cnt are held.
- Throughput: one pop per cycle while out_ready = 1. Latency from pop to out_valid is 1 cycle.
- Backpressure: out_valid & ~out_ready holds out_data and out_sel stable and forces pop = 0.
- q_enable:
  - Deasserting q_enable[cur] mid-burst rotates away on the next grant.
  - A masked queue keeps its data; nothing is dropped.
  - All-zero q_enable gives pop = 0.
- Simultaneous push and pop on the same queue is allowed and passed through unchanged; fifo occupancy rules govern.
- Reset (rst = 0 sampled at posedge):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - cur = NUM_FIFOS-1, so the first grant is queue 0 when eligible; cnt = 0.
  - push, pop and in_ready are held 0 combinationally while rst = 0.
  - Reset mid-burst or with a word pending discards the egress word; the fifo is reset by the same rst.
- Invariant for formal checks: pop implies ~empty[pop_sel] and q_enable[pop_sel]; push implies ~full.

Test Plan:
- Reset then idle: rst=0 for 2 cycles with in_valid=1 and empty=2'b00 → push=0, pop=0, in_ready=0, out_valid=0. Release rst → first pop has pop_sel=0.
- Burst rotation, NUM_FIFOS=2, BURST=2, both queues non-empty, out_ready=1 → pop_sel sequence 0,0,1,1,0,0. out_sel follows one cycle later, with out_valid=1 continuously.
- Sole eligible: only queue 1 non-empty, holding 5 words → five back-to-back pops with pop_sel=1 and no bubbles. cnt wraps 1,2,1,2,1.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 → pop=0 and out_data held constant. out_ready=1 → pop resumes in the same cycle.
- Mask: q_enable=2'b10 with both queues non-empty → only pop_sel=1. Set q_enable=2'b11 mid-burst on queue 1 → queue 0 is served after queue 1's burst completes.
- Full: full=1 with in_valid=1 → in_ready=0 and push=0. full falls → push=1 in the same cycle with push_sel=in_sel.
